// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage. It owns the architectural
// Hi/Lo registers and stalls ID/EX while a MULT/MULTU/DIV/DIVU iterates.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start_EX,
    input  logic [1:0]            Op_EX,
    input  logic [DATA_WIDTH-1:0] Operand_A_EX,
    input  logic [DATA_WIDTH-1:0] Operand_B_EX,
    input  logic                  Flush_EX,
    output logic                  Stall_ID_EX,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Div_By_Zero,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  count_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] acc_r;
    logic           is_div_r;
    logic           neg_q_r;
    logic           neg_rem_r;
    logic           dbz_r;

    logic           is_signed_s;
    logic           sign_a_s;
    logic           sign_b_s;
    logic [W:0]     mul_sum_s;
    logic [2*W-1:0] mul_next_s;
    logic [W:0]     div_shift_s;
    logic [W:0]     div_diff_s;
    logic [2*W-1:0] div_next_s;
    logic [2*W-1:0] prod_fix_s;
    logic [W-1:0]   hi_res_s;
    logic [W-1:0]   lo_res_s;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        neg_w = ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        neg_2w = ~v + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        magnitude = (is_signed && v[W-1]) ? neg_w(v) : v;
    endfunction

    assign Stall_ID_EX = ((state_r == IDLE) & Start_EX & ~Flush_EX) |
                         (state_r == MUL) | (state_r == DIV);
    assign Busy        = (state_r != IDLE);

    // Operand decode, one shift-add / restoring shift-subtract step, and sign fix-up.
    always_comb begin
        is_signed_s = ~Op_EX[0];
        sign_a_s    = is_signed_s & Operand_A_EX[W-1];
        sign_b_s    = is_signed_s & Operand_B_EX[W-1];
        // acc_r = {partial product, remaining multiplier bits}
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, b_r} : {(W+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[W-1:1]};
        // acc_r = {partial remainder, dividend bits shifting into quotient}
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        if (!div_diff_s[W]) begin
            div_next_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
        end
        prod_fix_s = neg_q_r ? neg_2w(acc_r) : acc_r;
        if (is_div_r) begin
            hi_res_s = neg_rem_r ? neg_w(acc_r[2*W-1:W]) : acc_r[2*W-1:W];
            lo_res_s = neg_q_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
        end else begin
            hi_res_s = prod_fix_s[2*W-1:W];
            lo_res_s = prod_fix_s[W-1:0];
        end
    end

    // Sequencer, iteration datapath and architectural Hi/Lo registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            count_r     <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            is_div_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            dbz_r       <= 1'b0;
            Hi          <= '0;
            Lo          <= '0;
            Done        <= 1'b0;
            Div_By_Zero <= 1'b0;
        end else begin
            Done        <= 1'b0;
            Div_By_Zero <= 1'b0;
            if (Flush_EX) begin
                state_r <= IDLE;
                count_r <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (Start_EX) begin
                            count_r   <= '0;
                            b_r       <= magnitude(Operand_B_EX, is_signed_s);
                            is_div_r  <= Op_EX[1];
                            acc_r     <= {{W{1'b0}}, magnitude(Operand_A_EX, is_signed_s)};
                            neg_q_r   <= sign_a_s ^ sign_b_s;
                            neg_rem_r <= sign_a_s;
                            dbz_r     <= 1'b0;
                            if (Op_EX[1] && (Operand_B_EX == {W{1'b0}})) begin
                                // Divide by zero: Hi = A, Lo = all ones, no iterations.
                                acc_r     <= {Operand_A_EX, {W{1'b1}}};
                                neg_q_r   <= 1'b0;
                                neg_rem_r <= 1'b0;
                                dbz_r     <= 1'b1;
                                state_r   <= FINISH;
                            end else if (Op_EX[1]) begin
                                state_r <= DIV;
                            end else begin
                                state_r <= MUL;
                            end
                        end
                    end
                    MUL, DIV: begin
                        acc_r <= (state_r == MUL) ? mul_next_s : div_next_s;
                        if (count_r == CW'(W-1)) begin
                            count_r <= '0;
                            state_r <= FINISH;
                        end else begin
                            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    FINISH: begin
                        Hi          <= hi_res_s;
                        Lo          <= lo_res_s;
                        Done        <= 1'b1;
                        Div_By_Zero <= dbz_r;
                        state_r     <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an arithmetic reference model drives the
// expected Hi/Lo/Done/Div_By_Zero that a per-cycle monitor compares against the DUT.
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start_EX = 1'b0;
    logic         Flush_EX = 1'b0;
    logic [1:0]   Op_EX = 2'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Stall_ID_EX, Busy, Done, Div_By_Zero;
    logic [W-1:0] Hi, Lo;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_done = 1'b0;
    logic         exp_dbz = 1'b0;
    bit           mon_en = 1'b0;

    always #5 Clk = ~Clk;

    ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start_EX(Start_EX), .Op_EX(Op_EX),
        .Operand_A_EX(A), .Operand_B_EX(B), .Flush_EX(Flush_EX),
        .Stall_ID_EX(Stall_ID_EX), .Busy(Busy), .Done(Done),
        .Div_By_Zero(Div_By_Zero), .Hi(Hi), .Lo(Lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic with C-style truncating division.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 2'd2) begin
                    q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
                end else begin
                    hi = a % b; lo = a / b;
                end
            end
        endcase
    endfunction

    // Outputs are checked against the model on every cycle once out of reset.
    always @(negedge Clk) begin
        if (mon_en) begin
            check("hi", Hi, exp_hi);
            check("lo", Lo, exp_lo);
            check("done", Done, exp_done);
            check("div_by_zero", Div_By_Zero, exp_dbz);
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Start_EX = 1'b1; Op_EX = op; A = a; B = b;
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int           stalls;
        logic [W-1:0] mh, ml;
        logic         md;
        stalls = 0;
        model(op, a, b, mh, ml, md);
        start_op(op, a, b);
        while (Stall_ID_EX && stalls < 60) begin
            stalls++;
            @(negedge Clk); #1;
        end
        check("stall_cycles", stalls, (op[1] && b == '0) ? 1 : 33);
        @(posedge Clk); #1;
        Start_EX = 1'b0;
        exp_hi = mh; exp_lo = ml; exp_done = 1'b1; exp_dbz = md;
        check("busy_after_write", Busy, 0);
        @(posedge Clk); #1;
        exp_done = 1'b0; exp_dbz = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] mh, ml;
        logic         md;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        int           n;

        // Hand-computed values pin the reference model itself.
        model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mh, ml, md);
        check("model_multu", {mh, ml}, 64'hFFFF_FFFE_0000_0001);
        model(2'd0, 32'hFFFF_FFFD, 32'd7, mh, ml, md);
        check("model_mult", {mh, ml}, 64'hFFFF_FFFF_FFFF_FFEB);
        model(2'd2, 32'hFFFF_FFF9, 32'd2, mh, ml, md);
        check("model_div", {mh, ml}, 64'hFFFF_FFFF_FFFF_FFFD);
        model(2'd3, 32'd100, 32'd7, mh, ml, md);
        check("model_divu", {mh, ml}, 64'h0000_0002_0000_000E);
        model(2'd3, 32'd5, 32'd0, mh, ml, md);
        check("model_dbz", {md, mh, ml}, {1'b1, 64'h0000_0005_FFFF_FFFF});
        model(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mh, ml, md);
        check("model_ovf", {md, mh, ml}, {1'b0, 64'h0000_0000_8000_0000});

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_stall", Stall_ID_EX, 0);
        check("rst_hilo", {Hi, Lo}, 64'd0);
        check("rst_done", {Done, Div_By_Zero}, 2'b00);
        Reset_n = 1'b1;
        mon_en  = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'd100, 32'd7);
        run_op(2'd3, 32'd5, 32'd0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'h8000_0000, 32'd0);

        // Flush at iteration 10: back to IDLE, Hi/Lo untouched, no Done.
        start_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge Clk);
        Flush_EX = 1'b1; #1;
        check("flush_stall_mid", Stall_ID_EX, 1);
        @(posedge Clk); #1;
        Flush_EX = 1'b0; Start_EX = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_stall_after", Stall_ID_EX, 0);
        repeat (40) @(negedge Clk);

        // Flush in FINISH wins over the Hi/Lo write.
        start_op(2'd2, 32'd1000, 32'd3);
        n = 0;
        while (Stall_ID_EX && n < 60) begin n++; @(negedge Clk); #1; end
        check("finish_reached", n, 33);
        Flush_EX = 1'b1;
        @(posedge Clk); #1;
        Flush_EX = 1'b0; Start_EX = 1'b0;
        check("flush_finish_busy", Busy, 0);
        repeat (5) @(negedge Clk);

        // Reset mid-MUL clears Hi/Lo and discards the operation.
        start_op(2'd0, 32'h7FFF_0001, 32'h0000_0003);
        repeat (5) @(negedge Clk);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        exp_hi = '0; exp_lo = '0;
        Start_EX = 1'b0;
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
